gray_ptr_sync: RTL and testbench
================================

# gray_ptr_sync

Registered Gray-code pointer generator and cross-domain pointer comparator for one side of an asynchronous FIFO. The block holds the local binary pointer and its registered Gray image. It synchronises the peer domain's Gray pointer through a parametrised flop chain and converts it back to binary. It produces a registered full flag (write side) or empty flag (read side). One instance sits in each clock domain of every async FIFO in the design.

## Interface
- PTR, 8, pointer MSB index; pointers are PTR+1 bits, FIFO depth 2^PTR; legal PTR ≥ 2
- SYNC_STAGES, 2, synchroniser depth for remote_gray; legal 2..4
- SIDE, 0, 0 = read side (flag means empty), 1 = write side (flag means full)
- Reset is asynchronous and active-low; single clock.
- clk  input  1  domain clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- inc_en  input  1  request to advance pointer one slot (push on write side, pop on read side)
- clr  input  1  synchronous clear of local pointer
- remote_gray  input  PTR+1  peer domain's registered Gray pointer; asynchronous to clk
- bin_ptr  output  PTR+1  local binary pointer, registered
- gray_ptr  output  PTR+1  Gray image of bin_ptr, registered; drives the peer's remote_gray
- addr  output  PTR  RAM address, equal to bin_ptr[PTR-1:0]
- remote_bin  output  PTR+1  binary of the last synchroniser stage
- flag  output  1  registered empty (SIDE=0) or full (SIDE=1)
- level  output  PTR+1  registered occupancy (SIDE=1) or available entries (SIDE=0); only with macro

## Operation
- Accept: inc_q = inc_en & ~flag. A request is ignored while flag=1, so there is no over/underflow.
- Next pointer: bin_nxt = clr ? 0 : bin_ptr + inc_q, modulo 2^(PTR+1). Wrap from all-ones to 0 is silent.
- gray_nxt = bin_nxt ^ (bin_nxt >> 1). gray_ptr is loaded from gray_nxt, never computed from bin_ptr combinationally, so gray_ptr is glitch-free.
- Synchroniser: remote_gray → s[0] → … → s[SYNC_STAGES-1]. There is no logic between stages.
- remote_bin[PTR] = s_last[PTR]; remote_bin[i] = remote_bin[i+1] ^ s_last[i]. This is combinational from the last stage.
- Empty (SIDE=0): flag_nxt = (gray_nxt == s_last).
- Full (SIDE=1): flag_nxt = (gray_nxt == {~s_last[PTR:PTR-1], s_last[PTR-2:0]}).
- clr has priority over inc_en. The synchroniser is not cleared by clr.
- Simultaneous inc_en and a remote change: flag_nxt uses the post-increment local pointer and the current s_last. This is pessimistic and always safe.
- Reset values:
  - bin_ptr, gray_ptr, addr, remote_bin, level, all sync stages: 0
  - flag: 1 for SIDE=0, 0 for SIDE=1
- Reset asserted mid-operation clears everything immediately and asynchronously. Both FIFO sides must be reset together; the block does not detect one-sided reset.

## Timing
- Accepted inc_en at edge N: bin_ptr, gray_ptr, addr are updated after edge N, i.e. a 1-cycle latency.
- flag is updated on the same edge as the pointer that causes it. For example, the 2^PTR-th accepted push raises full at that edge.
- A remote_gray change sampled at edge N reaches s_last after edge N+SYNC_STAGES-1. It affects flag and level after edge N+SYNC_STAGES.
- The flag release path is latency-only: full/empty deassert late, never early.

## Configuration
- GRAY_PTR_LEVEL_EN defined:
  - level register present and updated every cycle.
  - SIDE=1: level = bin_nxt − remote_bin.
  - SIDE=0: level = remote_bin − bin_nxt.
  - Both are modulo 2^(PTR+1), range 0..2^PTR.
- Undefined: level is tied to 0 and no subtractor is synthesised. The port stays present.

## Test plan
- Reset, PTR=3, SIDE=0: with rst_n=0, flag=1 and all vectors 0. Release reset with remote_gray=0; flag stays 1.
- Fill, PTR=3, SIDE=1, remote_gray=0:
  - 8 consecutive inc_en: full rises at the 8th edge, bin_ptr=8, gray_ptr=4'b1100.
  - A 9th inc_en is ignored; bin_ptr stays 8.
- Sync latency, SIDE=0, SYNC_STAGES=2, local ptr 0:
  - remote_gray 0→4'b0001 sampled at edge N: empty falls after edge N+2, remote_bin=1 after edge N+1.
- Wrap, PTR=3:
  - Walk bin_ptr 0..15 with remote tracking: gray_ptr changes exactly one bit per step.
  - At 15→0, gray goes 4'b1000→4'b0000 and flag is correct across the wrap.
- clr with inc_en both high at bin_ptr=5: next bin_ptr=0, gray_ptr=0. The synchroniser contents are unchanged.
- GRAY_PTR_LEVEL_EN, SIDE=1, PTR=3: after 5 pushes with remote_bin=2 settled, level=3. Without the macro, level=0.

Source files
------------

// File: rtl/gray_ptr_sync_if.sv
// Pointer/flag bundle between one async-FIFO side controller and its gray_ptr_sync block.
// The block uses the slave modport; the controller uses the master modport.
interface gray_ptr_sync_if #(
  parameter int PTR = 8
);
  logic         inc_en;
  logic         clr;
  logic [PTR:0] remote_gray;
  logic [PTR:0] bin_ptr;
  logic [PTR:0] gray_ptr;
  logic [PTR-1:0] addr;
  logic [PTR:0] remote_bin;
  logic         flag;
  logic [PTR:0] level;

  modport master (
    output inc_en, clr, remote_gray,
    input  bin_ptr, gray_ptr, addr, remote_bin, flag, level
  );

  modport slave (
    input  inc_en, clr, remote_gray,
    output bin_ptr, gray_ptr, addr, remote_bin, flag, level
  );
endinterface

// File: rtl/gray_ptr_sync.sv
// One side of an async FIFO: registered binary/Gray pointer, remote Gray synchroniser, empty/full flag.
// Optional occupancy/availability output enabled by defining GRAY_PTR_LEVEL_EN.
module gray_ptr_sync #(
  parameter int PTR         = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SIDE        = 0
) (
  input logic            clk,
  input logic            rst_n,
  gray_ptr_sync_if.slave bus
);
  logic [PTR:0] bin_q, bin_d;
  logic [PTR:0] gray_q, gray_d;
  logic         flag_q, flag_d;
  logic [PTR:0] sync_q [SYNC_STAGES];
  logic [PTR:0] sync_d [SYNC_STAGES];
  logic [PTR:0] s_last;
  logic [PTR:0] remote_bin;
  logic [PTR:0] full_cmp;
  logic         inc_acc;

  assign s_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = bus.remote_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= PTR; gi++) begin : g_g2b
    assign remote_bin[gi] = ^s_last[PTR:gi];
  end

  always_comb begin
    inc_acc  = bus.inc_en & ~flag_q;
    bin_d    = bus.clr ? '0 : bin_q + {{PTR{1'b0}}, inc_acc};
    gray_d   = bin_d ^ (bin_d >> 1);
    full_cmp = {~s_last[PTR:PTR-1], s_last[PTR-2:0]};
    flag_d   = (SIDE == 1) ? (gray_d == full_cmp) : (gray_d == s_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      flag_q <= (SIDE == 0);
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      flag_q <= flag_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

`ifdef GRAY_PTR_LEVEL_EN
  logic [PTR:0] level_q, level_d;

  always_comb begin
    level_d = (SIDE == 1) ? (bin_d - remote_bin) : (remote_bin - bin_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign bus.level = level_q;
`else
  assign bus.level = '0;
`endif

  assign bus.bin_ptr    = bin_q;
  assign bus.gray_ptr   = gray_q;
  assign bus.addr       = bin_q[PTR-1:0];
  assign bus.remote_bin = remote_bin;
  assign bus.flag       = flag_q;
endmodule

// File: tb/tb_gray_ptr_sync.sv
// Bench for gray_ptr_sync: read-side and write-side instances (PTR=3, 2 sync stages)
// checked against an integer-count model of pointers, delayed remote pointer and flags.
module tb_gray_ptr_sync;
  localparam int PTR = 3;
  localparam int MOD = 16;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;

  gray_ptr_sync_if #(.PTR(PTR)) if_rd ();
  gray_ptr_sync_if #(.PTR(PTR)) if_wr ();

  gray_ptr_sync #(.PTR(PTR), .SYNC_STAGES(2), .SIDE(0)) dut_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rd)
  );

  gray_ptr_sync #(.PTR(PTR), .SYNC_STAGES(2), .SIDE(1)) dut_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int step_cnt = 0;

  // stimulus, index 0 = read side, 1 = write side; remote kept as a binary count
  int inc_v [2];
  int clr_v [2];
  int rem_v [2];

  // model: local count, remote count as seen two and one edges ago, flag, level
  int m_loc  [2];
  int m_s0   [2];
  int m_s1   [2];
  int m_flag [2];
  int m_lvl  [2];

  task automatic check_val(input string tag, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_loc[k] = 0; m_s0[k] = 0; m_s1[k] = 0; m_lvl[k] = 0;
    end
    m_flag[0] = 1;
    m_flag[1] = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int acc, nl, seen;
      acc  = (inc_v[k] != 0 && m_flag[k] == 0) ? 1 : 0;
      nl   = (clr_v[k] != 0) ? 0 : (m_loc[k] + acc) % MOD;
      seen = m_s1[k];
      if (k == 0) m_flag[k] = (nl == seen) ? 1 : 0;
      else        m_flag[k] = (nl == (seen + DEPTH) % MOD) ? 1 : 0;
`ifdef GRAY_PTR_LEVEL_EN
      m_lvl[k] = (k == 1) ? (nl - seen + MOD) % MOD : (seen - nl + MOD) % MOD;
`else
      m_lvl[k] = 0;
`endif
      m_s1[k]  = m_s0[k];
      m_s0[k]  = rem_v[k];
      m_loc[k] = nl;
    end
  endtask

  task automatic check_all();
    check_val("rd_bin",   int'(if_rd.bin_ptr),    m_loc[0]);
    check_val("rd_gray",  int'(if_rd.gray_ptr),   to_gray(m_loc[0]));
    check_val("rd_addr",  int'(if_rd.addr),       m_loc[0] % DEPTH);
    check_val("rd_flag",  int'(if_rd.flag),       m_flag[0]);
    check_val("rd_rbin",  int'(if_rd.remote_bin), m_s1[0]);
    check_val("rd_level", int'(if_rd.level),      m_lvl[0]);
    check_val("wr_bin",   int'(if_wr.bin_ptr),    m_loc[1]);
    check_val("wr_gray",  int'(if_wr.gray_ptr),   to_gray(m_loc[1]));
    check_val("wr_addr",  int'(if_wr.addr),       m_loc[1] % DEPTH);
    check_val("wr_flag",  int'(if_wr.flag),       m_flag[1]);
    check_val("wr_rbin",  int'(if_wr.remote_bin), m_s1[1]);
    check_val("wr_level", int'(if_wr.level),      m_lvl[1]);
  endtask

  task automatic step(input string what);
    @(negedge clk);
    if_rd.inc_en      = (inc_v[0] != 0);
    if_rd.clr         = (clr_v[0] != 0);
    if_rd.remote_gray = 4'(to_gray(rem_v[0]));
    if_wr.inc_en      = (inc_v[1] != 0);
    if_wr.clr         = (clr_v[1] != 0);
    if_wr.remote_gray = 4'(to_gray(rem_v[1]));
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    step_cnt++;
    $display("step %0d %s: rd ptr=%0d flag=%0d | wr ptr=%0d flag=%0d lvl=%0d",
             step_cnt, what, if_rd.bin_ptr, if_rd.flag, if_wr.bin_ptr, if_wr.flag, if_wr.level);
  endtask

  task automatic set_in(input int k, input int inc, input int clr, input int rem);
    inc_v[k] = inc;
    clr_v[k] = clr;
    rem_v[k] = rem % MOD;
  endtask

  initial begin
    int prev_gray;
    rst_n = 1'b0;
    set_in(0, 0, 0, 0);
    set_in(1, 0, 0, 0);
    if_rd.inc_en = 1'b0; if_rd.clr = 1'b0; if_rd.remote_gray = '0;
    if_wr.inc_en = 1'b0; if_wr.clr = 1'b0; if_wr.remote_gray = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    check_val("reset_rd_flag", int'(if_rd.flag), 1);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (2) step("idle_after_reset");
    check_val("empty_held", int'(if_rd.flag), 1);

    // fill the write side against a frozen remote read pointer of 0
    set_in(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step("fill");
    check_val("fill_full", int'(if_wr.flag), 1);
    check_val("fill_bin", int'(if_wr.bin_ptr), 8);
    check_val("fill_gray", int'(if_wr.gray_ptr), 12);
    step("push_when_full");
    check_val("full_ignored", int'(if_wr.bin_ptr), 8);
    set_in(1, 0, 0, 0);

    // synchroniser latency on the read side
    set_in(0, 0, 0, 1);
    step("remote_change");
    check_val("lat_n_flag", int'(if_rd.flag), 1);
    check_val("lat_n_rbin", int'(if_rd.remote_bin), 0);
    step("lat_n1");
    check_val("lat_n1_rbin", int'(if_rd.remote_bin), 1);
    check_val("lat_n1_flag", int'(if_rd.flag), 1);
    step("lat_n2");
    check_val("lat_n2_flag", int'(if_rd.flag), 0);

    // clear write side, settle remote=2, push 5, then clr with inc
    set_in(1, 0, 1, 2);
    step("wr_clr");
    set_in(1, 0, 0, 2);
    repeat (3) step("settle");
    set_in(1, 1, 0, 2);
    repeat (5) step("push");
    check_val("push5_bin", int'(if_wr.bin_ptr), 5);
`ifdef GRAY_PTR_LEVEL_EN
    check_val("push5_level", int'(if_wr.level), 3);
`else
    check_val("push5_level", int'(if_wr.level), 0);
`endif
    set_in(1, 1, 1, 2);
    step("clr_and_inc");
    check_val("clr_bin", int'(if_wr.bin_ptr), 0);
    check_val("clr_gray", int'(if_wr.gray_ptr), 0);
    check_val("clr_rbin_kept", int'(if_wr.remote_bin), 2);
    set_in(1, 0, 0, 2);

    // walk the read pointer through a full wrap with the remote running ahead
    set_in(0, 0, 1, 4);
    step("rd_clr");
    set_in(0, 0, 0, 4);
    repeat (3) step("rd_settle");
    for (int i = 0; i < 18; i++) begin
      prev_gray = int'(if_rd.gray_ptr);
      set_in(0, 1, 0, rem_v[0] + 1);
      step("wrap_walk");
      check_val("gray_one_bit", $countones(4'(prev_gray) ^ if_rd.gray_ptr), 1);
    end

    // randomized traffic on both sides
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        set_in(k, int'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0) ? 1 : 0,
               rem_v[k] + int'($urandom_range(0, 1)));
      end
      step("random");
    end

    // asynchronous reset away from any clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("async_rst_wr_flag", int'(if_wr.flag), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
